// File: rtl/btn_event_gen.sv
// Button event generator: turns a debounced, synchronous button level into
// press / tap / long / repeat / release events plus a running press count.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | button up, waiting for an accepted press
// S_PRESS   | button down, counting towards the long-press threshold
// S_LONG    | long press declared, o_held high, auto-repeat running
// S_WAIT_REL| button seen down without an accepted press; wait for release
module btn_event_gen #(
  parameter int unsigned      CNT_W         = 26,
  parameter logic [CNT_W-1:0] LONG_CYCLES   = 26'd25_000_000,
  parameter logic [CNT_W-1:0] REPEAT_CYCLES = 26'd5_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_state,
  input  logic       i_enable,
  output logic       o_press,
  output logic       o_tap,
  output logic       o_long,
  output logic       o_held,
  output logic       o_repeat,
  output logic       o_release,
  output logic [7:0] o_press_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESS    = 2'd1,
    S_LONG     = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  // Terminal counts; REPEAT_LAST is unused when repeat is disabled.
  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_CYCLES - CNT_W'(1);
  localparam logic             REPEAT_EN   = (REPEAT_CYCLES != '0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_nxt, tap_nxt, long_nxt, held_nxt, repeat_nxt, release_nxt;
  logic [7:0]       count_nxt;

  // State, hold counter and all outputs are registered together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      o_press       <= 1'b0;
      o_tap         <= 1'b0;
      o_long        <= 1'b0;
      o_held        <= 1'b0;
      o_repeat      <= 1'b0;
      o_release     <= 1'b0;
      o_press_count <= 8'd0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      o_press       <= press_nxt;
      o_tap         <= tap_nxt;
      o_long        <= long_nxt;
      o_held        <= held_nxt;
      o_repeat      <= repeat_nxt;
      o_release     <= release_nxt;
      o_press_count <= count_nxt;
    end
  end

  // Next-state and next-output decision; enable has priority over everything.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    tap_nxt     = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    release_nxt = 1'b0;
    held_nxt    = o_held;
    count_nxt   = o_press_count;

    if (!i_enable) begin
      // A button already down when enable returns must not count as a press.
      held_nxt  = 1'b0;
      cnt_nxt   = '0;
      state_nxt = i_btn_state ? S_WAIT_REL : S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          held_nxt = 1'b0;
          if (i_btn_state) begin
            state_nxt = S_PRESS;
            cnt_nxt   = '0;
            press_nxt = 1'b1;
            count_nxt = o_press_count + 8'd1;
          end
        end
        S_PRESS: begin
          if (!i_btn_state) begin
            // Release wins over reaching the threshold on the same edge.
            tap_nxt     = 1'b1;
            release_nxt = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = S_IDLE;
          end else if (cnt == LONG_LAST) begin
            long_nxt  = 1'b1;
            held_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_LONG;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_LONG: begin
          if (!i_btn_state) begin
            release_nxt = 1'b1;
            held_nxt    = 1'b0;
            cnt_nxt     = '0;
            state_nxt   = S_IDLE;
          end else if (!REPEAT_EN) begin
            cnt_nxt = '0;
          end else if (cnt == REPEAT_LAST) begin
            repeat_nxt = 1'b1;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_WAIT_REL: begin
          held_nxt = 1'b0;
          if (!i_btn_state) state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          held_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_btn_event_gen;

  localparam int LONG = 8;
  localparam int REP  = 4;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_btn_state;
  logic       i_enable;
  logic       o_press, o_tap, o_long, o_held, o_repeat, o_release;
  logic [7:0] o_press_count;

  int checks = 0;
  int errors = 0;

  btn_event_gen #(
    .CNT_W         (26),
    .LONG_CYCLES   (26'd8),
    .REPEAT_CYCLES (26'd4)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_btn_state   (i_btn_state),
    .i_enable      (i_enable),
    .o_press       (o_press),
    .o_tap         (o_tap),
    .o_long        (o_long),
    .o_held        (o_held),
    .o_repeat      (o_repeat),
    .o_release     (o_release),
    .o_press_count (o_press_count)
  );

  always #5 i_clk = ~i_clk;

  // Packed expectation: {press, tap, long, held, repeat, release, count[7:0]}
  typedef struct {
    logic        btn;
    logic        en;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [13:0] ev(input logic p, input logic t, input logic l,
                                     input logic h, input logic r, input logic rel,
                                     input logic [7:0] c);
    return {p, t, l, h, r, rel, c};
  endfunction

  function automatic vec_t mk(input logic btn, input logic en, input logic [13:0] exp);
    vec_t v;
    v.btn = btn;
    v.en  = en;
    v.exp = exp;
    return v;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [13:0] exp);
    logic [13:0] got;
    got = {o_press, o_tap, o_long, o_held, o_repeat, o_release, o_press_count};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got p,t,l,h,r,rel=%b count=%0d, expected p,t,l,h,r,rel=%b count=%0d",
               name, got[13:8], got[7:0], exp[13:8], exp[7:0]);
    end
  endtask

  logic [7:0] exp_cnt;

  initial begin
    // Short tap, then release exactly at the long threshold edge.
    vecs.push_back(mk(1, 1, ev(1, 0, 0, 0, 0, 0, 8'd1)));
    vecs.push_back(mk(1, 1, ev(0, 0, 0, 0, 0, 0, 8'd1)));
    vecs.push_back(mk(1, 1, ev(0, 0, 0, 0, 0, 0, 8'd1)));
    vecs.push_back(mk(0, 1, ev(0, 1, 0, 0, 0, 1, 8'd1)));
    vecs.push_back(mk(0, 1, ev(0, 0, 0, 0, 0, 0, 8'd1)));
    vecs.push_back(mk(1, 1, ev(1, 0, 0, 0, 0, 0, 8'd2)));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 1, ev(0, 0, 0, 0, 0, 0, 8'd2)));
    vecs.push_back(mk(0, 1, ev(0, 1, 0, 0, 0, 1, 8'd2)));
    vecs.push_back(mk(0, 1, ev(0, 0, 0, 0, 0, 0, 8'd2)));
    // Held while disabled, enable rises, keep holding: no press.
    vecs.push_back(mk(1, 0, ev(0, 0, 0, 0, 0, 0, 8'd2)));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(1, 1, ev(0, 0, 0, 0, 0, 0, 8'd2)));
    vecs.push_back(mk(0, 1, ev(0, 0, 0, 0, 0, 0, 8'd2)));
    vecs.push_back(mk(1, 1, ev(1, 0, 0, 0, 0, 0, 8'd3)));
    vecs.push_back(mk(0, 1, ev(0, 1, 0, 0, 0, 1, 8'd3)));
    vecs.push_back(mk(0, 1, ev(0, 0, 0, 0, 0, 0, 8'd3)));
    // Enable drops mid-press: aborts without tap or release.
    vecs.push_back(mk(1, 1, ev(1, 0, 0, 0, 0, 0, 8'd4)));
    vecs.push_back(mk(1, 0, ev(0, 0, 0, 0, 0, 0, 8'd4)));
    vecs.push_back(mk(0, 0, ev(0, 0, 0, 0, 0, 0, 8'd4)));
    vecs.push_back(mk(0, 1, ev(0, 0, 0, 0, 0, 0, 8'd4)));

    // Reset and idle.
    i_rst       = 1'b1;
    i_btn_state = 1'b0;
    i_enable    = 1'b1;
    tick();
    tick();
    check("reset_state", ev(0, 0, 0, 0, 0, 0, 8'd0));
    i_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("idle[%0d]", i), ev(0, 0, 0, 0, 0, 0, 8'd0));
    end

    // Table vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      i_btn_state = vecs[i].btn;
      i_enable    = vecs[i].en;
      tick();
      check($sformatf("vec[%0d]", i), vecs[i].exp);
    end

    // 25-cycle hold: long at +8, repeats every 4 after that.
    exp_cnt     = 8'd5;
    i_enable    = 1'b1;
    i_btn_state = 1'b1;
    tick();
    check("hold_press", ev(1, 0, 0, 0, 0, 0, exp_cnt));
    for (int i = 1; i < 25; i++) begin
      tick();
      check($sformatf("hold[%0d]", i),
            ev(0, 0, i == LONG, i >= LONG, (i > LONG) && ((i - LONG) % REP == 0), 0, exp_cnt));
    end
    i_btn_state = 1'b0;
    tick();
    check("hold_release", ev(0, 0, 0, 0, 0, 1, exp_cnt));
    tick();
    check("hold_after", ev(0, 0, 0, 0, 0, 0, exp_cnt));

    // 256 taps: count walks through 255 -> 0 and back to its start.
    for (int k = 0; k < 256; k++) begin
      i_btn_state = 1'b1;
      tick();
      exp_cnt = exp_cnt + 8'd1;
      check($sformatf("tap_press[%0d]", k), ev(1, 0, 0, 0, 0, 0, exp_cnt));
      i_btn_state = 1'b0;
      tick();
      check($sformatf("tap_rel[%0d]", k), ev(0, 1, 0, 0, 0, 1, exp_cnt));
    end

    // Reset while in LONG clears immediately, with no release afterwards.
    i_btn_state = 1'b1;
    tick();
    exp_cnt = exp_cnt + 8'd1;
    check("rst_press", ev(1, 0, 0, 0, 0, 0, exp_cnt));
    for (int i = 1; i <= 10; i++) tick();
    check("rst_in_long", ev(0, 0, 0, 1, 0, 0, exp_cnt));
    #2;
    i_rst       = 1'b1;
    i_btn_state = 1'b0;
    #1;
    check("rst_async", ev(0, 0, 0, 0, 0, 0, 8'd0));
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_after[%0d]", i), ev(0, 0, 0, 0, 0, 0, 8'd0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
